// File: rtl/remote_cmd_pkg.sv
// rtl/remote_cmd_pkg.sv - shared types and constants for the remote command sequencer
package remote_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TX_HI     = 2'd1,
    ST_TX_LO     = 2'd2,
    ST_WAIT_RESP = 2'd3
  } seq_state_e;

  localparam logic [7:0] RESP_DONE  = 8'hA5;
  localparam logic [7:0] RESP_PROG  = 8'h5A;
  localparam int         FRAME_BITS = 10;
  localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);

endpackage

// File: rtl/uart_byte_xcvr.sv
// rtl/uart_byte_xcvr.sv - 8N1 byte transmitter and mid-bit sampling receiver
module uart_byte_xcvr #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_done,
  output logic       o_tx,
  input  logic       i_rx,
  output logic       o_rx_rdy,
  output logic [7:0] o_rx_data,
  output logic       o_rx_ferr
);
  import remote_cmd_pkg::*;

  localparam int            BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);

  logic [9:0]    r_tx_sh;
  logic [BW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bit;
  logic          r_tx_busy;
  logic          w_tx_bit_end;

  assign w_tx_bit_end = r_tx_busy && (r_tx_baud == BAUD_LAST);
  assign o_tx_done    = w_tx_bit_end && (r_tx_bit == LAST_BIT);
  assign o_tx         = r_tx_sh[0];

  // A start arriving in the final stop cycle reloads directly, so frames chain with no idle gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sh   <= '1;
      r_tx_baud <= '0;
      r_tx_bit  <= '0;
      r_tx_busy <= 1'b0;
    end else if (i_tx_start && (!r_tx_busy || o_tx_done)) begin
      r_tx_sh   <= {1'b1, i_tx_data, 1'b0};
      r_tx_baud <= '0;
      r_tx_bit  <= '0;
      r_tx_busy <= 1'b1;
    end else if (o_tx_done) begin
      r_tx_sh   <= '1;
      r_tx_baud <= '0;
      r_tx_bit  <= '0;
      r_tx_busy <= 1'b0;
    end else if (w_tx_bit_end) begin
      r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
      r_tx_baud <= '0;
      r_tx_bit  <= r_tx_bit + 4'd1;
    end else if (r_tx_busy) begin
      r_tx_baud <= r_tx_baud + BW'(1);
    end
  end

  logic [1:0]    r_rx_sync;
  logic          r_rx_prev;
  logic          r_rx_busy;
  logic [BW-1:0] r_rx_baud;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic          r_rx_rdy;
  logic          r_rx_ferr;
  logic [7:0]    r_rx_data;
  logic          w_rxs;

  assign w_rxs     = r_rx_sync[1];
  assign o_rx_rdy  = r_rx_rdy;
  assign o_rx_ferr = r_rx_ferr;
  assign o_rx_data = r_rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sync <= 2'b11;
      r_rx_prev <= 1'b1;
      r_rx_busy <= 1'b0;
      r_rx_baud <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_rx_rdy  <= 1'b0;
      r_rx_ferr <= 1'b0;
      r_rx_data <= '0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], i_rx};
      r_rx_prev <= w_rxs;
      r_rx_rdy  <= 1'b0;
      r_rx_ferr <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_prev && !w_rxs) begin
          r_rx_busy <= 1'b1;
          r_rx_baud <= '0;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_bit == 4'd0) begin
        // Start bit must still be low at its midpoint, otherwise it was a glitch
        if (r_rx_baud == BAUD_HALF) begin
          if (w_rxs) begin
            r_rx_busy <= 1'b0;
          end else begin
            r_rx_baud <= '0;
            r_rx_bit  <= 4'd1;
          end
        end else begin
          r_rx_baud <= r_rx_baud + BW'(1);
        end
      end else if (r_rx_baud == BAUD_LAST) begin
        r_rx_baud <= '0;
        if (r_rx_bit == LAST_BIT) begin
          r_rx_busy <= 1'b0;
          if (w_rxs) begin
            r_rx_rdy  <= 1'b1;
            r_rx_data <= r_rx_sh;
          end else begin
            r_rx_ferr <= 1'b1;
          end
        end else begin
          r_rx_sh  <= {w_rxs, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 4'd1;
        end
      end else begin
        r_rx_baud <= r_rx_baud + BW'(1);
      end
    end
  end

endmodule

// File: rtl/remote_cmd_seq.sv
// rtl/remote_cmd_seq.sv - host command sequencer: sends a 16-bit command, waits for done or timeout
module remote_cmd_seq #(
  parameter int          BAUD_DIV = 5208,
  parameter int unsigned RESP_TMO = 'h3FF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  input  logic        RX,
  output logic        TX,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        busy,
  output logic        tmo_err
);
  import remote_cmd_pkg::*;

  localparam int            TW      = $clog2(RESP_TMO + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(RESP_TMO);

  seq_state_e    r_state;
  logic [15:0]   r_hold;
  logic [TW-1:0] r_tmo;
  logic          r_busy;
  logic          r_cmd_snt;
  logic          r_tmo_err;

  logic          w_accept;
  logic          w_tx_start;
  logic [7:0]    w_tx_data;
  logic          w_tx_done;
  logic          w_rx_rdy;
  logic [7:0]    w_rx_data;
  logic          w_rx_ferr_unused;
  logic [TW-1:0] w_tmo_nxt;

  // The high byte goes straight from cmd so the start bit leaves one cycle after accept
  assign w_accept   = (r_state == ST_IDLE) && snd_cmd;
  assign w_tx_start = w_accept || ((r_state == ST_TX_HI) && w_tx_done);
  assign w_tx_data  = w_accept ? cmd[15:8] : r_hold[7:0];
  assign w_tmo_nxt  = (r_tmo == TMO_MAX) ? r_tmo : r_tmo + TW'(1);

  assign busy     = r_busy;
  assign cmd_snt  = r_cmd_snt;
  assign tmo_err  = r_tmo_err;
  assign resp     = w_rx_data;
  assign resp_rdy = w_rx_rdy;

  uart_byte_xcvr #(
    .BAUD_DIV (BAUD_DIV)
  ) u_xcvr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tx_start (w_tx_start),
    .i_tx_data  (w_tx_data),
    .o_tx_done  (w_tx_done),
    .o_tx       (TX),
    .i_rx       (RX),
    .o_rx_rdy   (w_rx_rdy),
    .o_rx_data  (w_rx_data),
    .o_rx_ferr  (w_rx_ferr_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_tmo     <= '0;
      r_busy    <= 1'b0;
      r_cmd_snt <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      r_cmd_snt <= 1'b0;
      r_tmo_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (snd_cmd) begin
            r_hold  <= cmd;
            r_busy  <= 1'b1;
            r_state <= ST_TX_HI;
          end
        end
        ST_TX_HI: begin
          if (w_tx_done) r_state <= ST_TX_LO;
        end
        ST_TX_LO: begin
          if (w_tx_done) begin
            r_cmd_snt <= 1'b1;
            r_tmo     <= '0;
            r_state   <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          // A byte landing on the expiry cycle takes priority over the timeout
          if (w_rx_rdy) begin
            r_tmo <= '0;
            if (w_rx_data == RESP_DONE) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_tmo <= w_tmo_nxt;
            if (w_tmo_nxt == TMO_MAX) begin
              r_tmo_err <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_cmd_seq.sv
// tb/tb_remote_cmd_seq.sv - directed self-checking bench for remote_cmd_seq
module tb_remote_cmd_seq;
  import remote_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic        cmd_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        busy;
  logic        tmo_err;

  always #5 clk = ~clk;

  remote_cmd_seq #(
    .BAUD_DIV (16),
    .RESP_TMO (1000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .RX       (RX),
    .TX       (TX),
    .cmd_snt  (cmd_snt),
    .resp     (resp),
    .resp_rdy (resp_rdy),
    .busy     (busy),
    .tmo_err  (tmo_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  int   cyc = 0;
  int   rdy_cnt = 0;
  int   tmo_cnt = 0;
  int   rdy_cyc = 0;
  int   fall_cyc = 0;
  int   snt_cyc = 0;
  int   tmo_cyc = 0;
  logic busy_q = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= busy;
    if (resp_rdy) begin
      rdy_cnt <= rdy_cnt + 1;
      rdy_cyc <= cyc;
    end
    if (busy_q && !busy) fall_cyc <= cyc;
    if (tmo_err) begin
      tmo_cnt <= tmo_cnt + 1;
      tmo_cyc <= cyc;
    end
    if (cmd_snt) snt_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends c and checks the full TX waveform; optionally pokes a second request during TX_HI
  task automatic run_send(input logic [15:0] c, input bit inject);
    logic [9:0] fr_hi, fr_lo;
    logic       e;
    int         mism_hi, mism_lo, busy_low, snt_cnt, snt_at;
    fr_hi = {1'b1, c[15:8], 1'b0};
    fr_lo = {1'b1, c[7:0], 1'b0};
    mism_hi = 0; mism_lo = 0; busy_low = 0; snt_cnt = 0; snt_at = 0;
    cmd = c;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    cmd = 16'h0000;
    for (int k = 1; k <= 330; k++) begin
      if (inject && k == 40) begin
        cmd = 16'hFFFF;
        snd_cmd = 1'b1;
      end
      if (inject && k == 41) begin
        snd_cmd = 1'b0;
        cmd = 16'h0000;
      end
      if (k <= 160) begin
        e = fr_hi[(k - 1) / 16];
        if (TX !== e) mism_hi++;
      end else if (k <= 320) begin
        e = fr_lo[(k - 161) / 16];
        if (TX !== e) mism_lo++;
      end else if (TX !== 1'b1) begin
        mism_lo++;
      end
      if (k <= 321 && busy !== 1'b1) busy_low++;
      if (cmd_snt === 1'b1) begin
        snt_cnt++;
        if (snt_at == 0) snt_at = k;
      end
      tick();
    end
    check($sformatf("tx_hi_wave_%04h", c), 32'(mism_hi), 32'd0);
    check($sformatf("tx_lo_wave_%04h", c), 32'(mism_lo), 32'd0);
    check($sformatf("busy_during_tx_%04h", c), 32'(busy_low), 32'd0);
    check($sformatf("cmd_snt_cycle_%04h", c), 32'(snt_at), 32'd321);
    check($sformatf("cmd_snt_pulses_%04h", c), 32'(snt_cnt), 32'd1);
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit stop_ok);
    RX = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (16) tick();
    end
    RX = stop_ok;
    repeat (16) tick();
    RX = 1'b1;
    repeat (16) tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b_rdy, b_tmo;

    repeat (3) tick();
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_cmd_snt", 32'(cmd_snt), 32'd0);
    check("rst_resp", 32'(resp), 32'h00);
    check("rst_resp_rdy", 32'(resp_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmo_err", 32'(tmo_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_send(16'h2402, 1'b0);
    b_rdy = rdy_cnt;
    b_tmo = tmo_cnt;
    rx_byte(RESP_DONE, 1'b1);
    check("done_resp", 32'(resp), 32'hA5);
    check("done_rdy_pulses", 32'(rdy_cnt - b_rdy), 32'd1);
    check("done_busy_drop_lag", 32'(fall_cyc - rdy_cyc), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_no_tmo", 32'(tmo_cnt - b_tmo), 32'd0);

    run_send(16'h81C3, 1'b0);
    b_rdy = rdy_cnt;
    b_tmo = tmo_cnt;
    for (int i = 0; i < 3; i++) begin
      rx_byte(RESP_PROG, 1'b1);
      check($sformatf("prog_resp_%0d", i), 32'(resp), 32'h5A);
      check($sformatf("prog_busy_%0d", i), 32'(busy), 32'd1);
    end
    rx_byte(RESP_DONE, 1'b1);
    check("prog_rdy_pulses", 32'(rdy_cnt - b_rdy), 32'd4);
    check("prog_busy_drop_lag", 32'(fall_cyc - rdy_cyc), 32'd1);
    check("prog_busy_end", 32'(busy), 32'd0);
    check("prog_no_tmo", 32'(tmo_cnt - b_tmo), 32'd0);

    run_send(16'h0F0F, 1'b0);
    b_tmo = tmo_cnt;
    for (int i = 0; i < 1200 && tmo_cnt == b_tmo; i++) tick();
    check("tmo_pulses", 32'(tmo_cnt - b_tmo), 32'd1);
    check("tmo_latency", 32'(tmo_cyc - snt_cyc), 32'd1000);
    check("tmo_busy", 32'(busy), 32'd0);

    run_send(16'h2402, 1'b1);
    b_rdy = rdy_cnt;
    RX = 1'b0;
    repeat (3) tick();
    RX = 1'b1;
    repeat (40) tick();
    check("glitch_no_rdy", 32'(rdy_cnt - b_rdy), 32'd0);
    rx_byte(8'h3C, 1'b0);
    check("ferr_no_rdy", 32'(rdy_cnt - b_rdy), 32'd0);
    check("ferr_resp_kept", 32'(resp), 32'hA5);
    rx_byte(8'hC3, 1'b1);
    check("after_ferr_resp", 32'(resp), 32'hC3);
    check("after_ferr_rdy", 32'(rdy_cnt - b_rdy), 32'd1);
    check("after_ferr_busy", 32'(busy), 32'd1);
    rx_byte(RESP_DONE, 1'b1);
    check("ignore_done_busy", 32'(busy), 32'd0);

    cmd = 16'h2402;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    repeat (232) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(TX), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("midrst_resp", 32'(resp), 32'h00);
    b_rdy = rdy_cnt;
    rx_byte(8'h66, 1'b1);
    check("idle_rx_resp", 32'(resp), 32'h66);
    check("idle_rx_rdy", 32'(rdy_cnt - b_rdy), 32'd1);
    check("idle_rx_busy", 32'(busy), 32'd0);
    run_send(16'h1111, 1'b0);
    rx_byte(RESP_DONE, 1'b1);
    check("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/remote_cmd_seq.md
Name: remote_cmd_seq

Overview:
- Host-side command sequencer that feeds the robot's BLE/UART command input.
- Accepts a 16-bit command from a host or bench driver.
- Serializes it as two 8N1 UART bytes, high byte first, on TX, which drives the robot's RX.
- Collects the robot's response bytes on RX, which is driven by the robot's TX, and runs until 0xA5 (done) is received or a timeout expires. 0x5A (in progress) is reported but does not end the command.

Parameters:
- BAUD_DIV, 5208: clocks per UART bit (50MHz / 9600 baud). Minimum 16.
- RESP_TMO, 26'h3FF_FFFF: idle clocks without a received byte before the command is abandoned.

Ports:
- clk  in  1  50MHz system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  16  command to send
- snd_cmd  in  1  one-cycle request; accepted only when busy=0
- RX  in  1  serial input from the robot's TX (asynchronous)
- TX  out  1  serial output to the robot's RX
- cmd_snt  out  1  one-cycle pulse when the low byte's stop bit completes
- resp  out  8  last response byte received
- resp_rdy  out  1  one-cycle pulse on each valid received byte
- busy  out  1  high from accept until return to IDLE
- tmo_err  out  1  one-cycle pulse on response timeout

Behaviour:
- Reset values: TX=1, cmd_snt=0, resp=8'h00, resp_rdy=0, busy=0, tmo_err=0. All counters cleared, FSM in IDLE. Reset mid-frame aborts immediately, TX goes high, and the next frame restarts cleanly.
- FSM states: IDLE, TX_HI, TX_LO, WAIT_RESP.
- IDLE:
  - snd_cmd=1 latches cmd into a holding register, sets busy the next cycle, and goes to TX_HI.
  - snd_cmd while busy=1 is ignored and the holding register is unchanged.
- TX_HI: transmits cmd[15:8]. The start bit begins 1 cycle after accept. Frame is start(0), 8 data bits LSB first, stop(1), each bit exactly BAUD_DIV clocks. At end of stop, go to TX_LO with no idle gap.
- TX_LO: transmits cmd[7:0] the same way. At end of stop, pulse cmd_snt, clear the timeout counter, and go to WAIT_RESP.
- Latency: cmd_snt arrives exactly 20*BAUD_DIV+1 clocks after the snd_cmd cycle.
- WAIT_RESP:
  - Each valid received byte loads resp and pulses resp_rdy in the same cycle, and clears the timeout counter.
  - If the byte is 8'hA5, busy drops the following cycle and the FSM goes to IDLE.
  - Any other byte (e.g. 8'h5A) keeps the FSM in WAIT_RESP.
  - When the timeout counter reaches RESP_TMO, pulse tmo_err, drop busy, and go to IDLE.
- Receiver (always enabled, including outside WAIT_RESP):
  - RX passes through a 2-flop synchronizer; the flop chain presets to 1 on reset.
  - A falling edge starts a frame. The start bit is re-sampled at BAUD_DIV/2; if it is high, it is a glitch: abort and stay idle.
  - Data bits are sampled at mid-bit.
  - Stop sampled as 0 is a framing error: the byte is discarded, with no resp_rdy and no resp update.
  - Bytes received outside WAIT_RESP update resp and pulse resp_rdy but never change FSM state.
- Simultaneous events:
  - A byte that completes in the same cycle as timeout expiry wins: resp_rdy pulses, tmo_err does not, and the timeout counter clears.
  - The cmd_snt cycle and a receiver completion in the same cycle are independent; both pulses are allowed.
- Width rules:
  - Baud counter: $clog2(BAUD_DIV) bits.
  - Timeout counter: $clog2(RESP_TMO+1) bits, saturating at RESP_TMO.
  - Bit counter: 4 bits, counting 0..9 per frame.

Decomposition:
- Package remote_cmd_pkg holds:
  - a typedef enum for the FSM states;
  - the constants RESP_DONE=8'hA5 and RESP_PROG=8'h5A;
  - the frame length of 10 bits.
- Sub-module uart_byte_xcvr holds the TX shifter and RX sampler with byte-level handshakes (tx_start/tx_done, rx_rdy/rx_data/rx_ferr) and is parameterized by BAUD_DIV.
- remote_cmd_seq holds only the FSM, the holding register and the timeout counter.

Test Plan:
- Basic send: BAUD_DIV=16, snd_cmd with cmd=16'h2402. Required: TX shows frames 0x24 then 0x02, LSB first. cmd_snt pulses at cycle 321 after the request. busy=1 throughout.
- Done response: after cmd_snt, drive byte 0xA5 on RX. Required: resp=8'hA5, a single resp_rdy pulse, busy=0 the next cycle, FSM in IDLE.
- Progress stream: drive 0x5A, 0x5A, 0x5A, then 0xA5 on RX. Required: 4 resp_rdy pulses; busy stays 1 until the cycle after 0xA5; tmo_err=0.
- Timeout: RESP_TMO=1000 with no RX activity after cmd_snt. Required: tmo_err pulses exactly 1000 clocks after cmd_snt, busy drops, and a new snd_cmd is accepted.
- Busy ignore and glitch: a second snd_cmd with cmd=16'hFFFF during TX_HI is ignored and TX still sends 0x24,0x02. A 3-clock low glitch on RX produces no resp_rdy. A stop bit forced low discards the byte.
- Reset mid-frame: assert rst_n low during TX_LO bit 4. Required: TX=1 and busy=0 immediately. After release, cmd=16'h1111 is sent correctly.
